spi_host_tx_byte_select: RTL



---
 rtl/spi_host_tx_byte_select.sv | 126 ++++++++++++
 1 files changed

// File: rtl/spi_host_tx_byte_select.sv
// Byte serializer for the SPI host TX path: buffers 32-bit words with byte enables
// and emits only the enabled bytes, one per handshake, to the shift engine.
module spi_host_tx_byte_select #(
  parameter int unsigned Depth     = 4,
  parameter bit          ByteOrder = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [31:0]                    word_i,
  input  logic [3:0]                     word_be_i,
  input  logic                           word_valid_i,
  input  logic                           flush_i,
  output logic [7:0]                     byte_o,
  output logic                           byte_valid_o,
  input  logic                           byte_ready_i,
  output logic                           byte_last_o,
  output logic [$clog2(Depth+1)-1:0]     depth_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           overflow_o
);

  localparam int unsigned CW = $clog2(Depth + 1);
  localparam int unsigned PW = $clog2(Depth);

  logic [31:0]   mem_data [Depth];
  logic [3:0]    mem_be   [Depth];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   stg_data;
  logic [3:0]    stg_mask;
  logic          overflow;

  logic [3:0]    sel;
  logic          single, hs, load, write, fifo_empty, room;
  logic          pop, bypass, push, drop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // One-hot pick of the next lane to emit from the remaining mask.
  always_comb begin
    sel = '0;
    if (ByteOrder) begin
      for (int i = 3; i >= 0; i--) begin
        if (stg_mask[i]) sel = 4'(1 << i);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (stg_mask[i]) sel = 4'(1 << i);
      end
    end
  end

  always_comb begin
    byte_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) byte_o = byte_o | stg_data[8*i +: 8];
    end
  end

  always_comb begin
    single     = ((stg_mask & (stg_mask - 4'd1)) == 4'd0) && (stg_mask != 4'd0);
    hs         = (stg_mask != 4'd0) && byte_ready_i;
    load       = (stg_mask == 4'd0) || (hs && single);
    write      = word_valid_i && (word_be_i != 4'd0) && !flush_i;
    fifo_empty = (count == '0);
    room       = (count < CW'(Depth));
    pop        = load && !fifo_empty && !flush_i;
    // An empty FIFO lets a write go straight to the stage with no extra cycle.
    bypass     = load && fifo_empty && write;
    push       = write && !bypass && (room || pop);
    drop       = write && !bypass && !(room || pop);
  end

  assign byte_valid_o = (stg_mask != 4'd0);
  assign byte_last_o  = single;
  assign depth_o      = count;
  assign full_o       = (count == CW'(Depth));
  assign empty_o      = (count == '0) && (stg_mask == 4'd0);
  assign overflow_o   = overflow;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= word_i;
      mem_be[wr_ptr]   <= word_be_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      stg_data <= '0;
      stg_mask <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      stg_mask <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
      if (load) begin
        if (pop) begin
          stg_data <= mem_data[rd_ptr];
          stg_mask <= mem_be[rd_ptr];
        end else if (bypass) begin
          stg_data <= word_i;
          stg_mask <= word_be_i;
        end else begin
          stg_mask <= '0;
        end
      end else if (hs) begin
        stg_mask <= stg_mask & ~sel;
      end
    end
  end

endmodule
